// File: rtl/ifetch_unit_if.sv
// Fetch-unit bus bundle: PC input handshake, instruction-memory req/gnt/rvalid
// channel, and the decode-side instruction handshake.
//   master : the fetch unit (drives imem_req/imem_addr, fetch_ready, instr*)
//   slave  : the environment (PC source, instruction memory, decode)
interface ifetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] pc_in;
  logic              pc_valid;
  logic              fetch_ready;
  logic              flush;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic [ADDR_W-1:0] pc4;
  logic              instr_ready;
  logic              misalign_err;

  modport master (
    input  pc_in, pc_valid, flush, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    output fetch_ready, imem_req, imem_addr, instr_valid, instr, instr_pc, pc4,
           misalign_err
  );

  modport slave (
    output pc_in, pc_valid, flush, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    input  fetch_ready, imem_req, imem_addr, instr_valid, instr, instr_pc, pc4,
           misalign_err
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction-fetch engine. Accepts a PC, issues one word read to instruction
// memory (req held until gnt, one outstanding), and holds the returned word
// with its PC and PC+4 until decode consumes it. Flush discards the fetch in
// flight or the held instruction.
// Ports:
//   clk  : clock, all state on posedge
//   rst  : synchronous active-low reset
//   bus  : ifetch_unit_if.master (pc_in/pc_valid/fetch_ready, flush,
//          imem_req/addr/gnt/rvalid/rdata, instr_valid/instr/instr_pc/pc4/
//          instr_ready, misalign_err)
module ifetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  ifetch_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);

  state_t            state;
  logic              drop;
  logic [ADDR_W-1:0] addr_q;
  logic              req_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic              valid_q;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic [ADDR_W-1:0] pc4_q;
  logic              misalign_q;
  logic              fetch_ready;
  logic              accept;

  // A held instruction being consumed frees the unit in the same cycle.
  assign fetch_ready = ~bus.flush & ((state == IDLE) | ((state == HOLD) & bus.instr_ready));
  assign accept      = bus.pc_valid & fetch_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      drop        <= 1'b0;
      addr_q      <= '0;
      req_q       <= 1'b0;
      imem_addr_q <= '0;
      valid_q     <= 1'b0;
      instr_q     <= '0;
      instr_pc_q  <= '0;
      pc4_q       <= '0;
      misalign_q  <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      case (state)
        IDLE: ;
        REQ: begin
          // A request is never withdrawn; a flush only marks the reply as stale.
          if (bus.flush) drop <= 1'b1;
          if (bus.imem_gnt) begin
            req_q <= 1'b0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            if (drop | bus.flush) begin
              drop  <= 1'b0;
              state <= IDLE;
            end else begin
              instr_q    <= bus.imem_rdata;
              instr_pc_q <= addr_q;
              pc4_q      <= addr_q + FOUR;
              valid_q    <= 1'b1;
              state      <= HOLD;
            end
          end else if (bus.flush) begin
            drop <= 1'b1;
          end
        end
        HOLD: begin
          // Flush voids the handshake even when instr_ready is high.
          if (bus.flush | bus.instr_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Accept only happens from IDLE or a consumed HOLD, so it overrides the
      // next-state chosen above.
      if (accept) begin
        addr_q <= bus.pc_in;
        if (|bus.pc_in[1:0]) begin
          misalign_q <= 1'b1;
          state      <= IDLE;
        end else begin
          req_q       <= 1'b1;
          imem_addr_q <= bus.pc_in;
          state       <= REQ;
        end
      end
    end
  end

  assign bus.fetch_ready  = fetch_ready;
  assign bus.imem_req     = req_q;
  assign bus.imem_addr    = imem_addr_q;
  assign bus.instr_valid  = valid_q;
  assign bus.instr        = instr_q;
  assign bus.instr_pc     = instr_pc_q;
  assign bus.pc4          = pc4_q;
  assign bus.misalign_err = misalign_q;
endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ifetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ifetch_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // memory side: automatic responder or manual directed drive
  logic        mem_auto = 1'b0;
  logic        a_gnt = 1'b0, a_rv = 1'b0;
  logic [31:0] a_rdata = '0;
  logic        man_gnt = 1'b0, man_rv = 1'b0;
  logic [31:0] man_rdata = '0;
  assign bus.imem_gnt    = mem_auto ? a_gnt   : man_gnt;
  assign bus.imem_rvalid = mem_auto ? a_rv    : man_rv;
  assign bus.imem_rdata  = mem_auto ? a_rdata : man_rdata;

  // reference model state
  exp_t        sb[$];
  int          mis_q[$];
  logic        mem_busy = 1'b0;
  logic        req_owed = 1'b0;
  logic [31:0] exp_req_addr = '0;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One cycle: inputs already driven; book the cycle after the monitor ran,
  // then return just after the next rising edge.
  task automatic tick();
    exp_t        e;
    logic        exp_rdy;
    logic [31:0] p;
    @(negedge clk);
    #2;
    if (!rst) begin
      sb.delete();
      mis_q.delete();
      mem_busy = 1'b0;
      req_owed = 1'b0;
    end else begin
      exp_rdy = !bus.flush && ((sb.size() == 0) ? !mem_busy : (!mem_busy && bus.instr_ready));
      chk("fetch_ready", {31'b0, bus.fetch_ready}, {31'b0, exp_rdy});
      if (bus.flush) sb.delete();
      if (bus.imem_rvalid && mem_busy) mem_busy = 1'b0;
      if (bus.pc_valid && bus.fetch_ready) begin
        p = bus.pc_in;
        if (p[1:0] != 2'b00) mis_q.push_back(cyc + 1);
        else begin
          e.instr = memf(p);
          e.pc    = p;
          e.pc4   = p + 32'd4;
          sb.push_back(e);
          mem_busy     = 1'b1;
          req_owed     = 1'b1;
          exp_req_addr = p;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_imem_req"},     {31'b0, bus.imem_req}, 32'h0);
    chk({tag, "_imem_addr"},    bus.imem_addr, 32'h0);
    chk({tag, "_instr_valid"},  {31'b0, bus.instr_valid}, 32'h0);
    chk({tag, "_instr"},        bus.instr, 32'h0);
    chk({tag, "_instr_pc"},     bus.instr_pc, 32'h0);
    chk({tag, "_pc4"},          bus.pc4, 32'h0);
    chk({tag, "_misalign_err"}, {31'b0, bus.misalign_err}, 32'h0);
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.instr_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_instr_valid actual=1 expected=0 (cycle %0d)", cyc);
        end else begin
          chk("instr",    bus.instr,    sb[0].instr);
          chk("instr_pc", bus.instr_pc, sb[0].pc);
          chk("pc4",      bus.pc4,      sb[0].pc4);
          if (bus.instr_ready && !bus.flush) void'(sb.pop_front());
        end
      end
      if (bus.misalign_err === 1'b1) begin
        checks++;
        if (mis_q.size() > 0 && mis_q[0] == cyc) void'(mis_q.pop_front());
        else begin
          failures++;
          $display("FAIL misalign_err actual=1 expected=0 (cycle %0d)", cyc);
        end
      end else if (mis_q.size() > 0 && mis_q[0] <= cyc) begin
        checks++;
        failures++;
        $display("FAIL misalign_err actual=0 expected=1 (cycle %0d)", cyc);
        void'(mis_q.pop_front());
      end
    end
  end

  // Automatic memory: random gnt delay 0..3, rvalid 1..3 cycles after gnt,
  // junk rdata otherwise, occasional stray rvalid while the unit is idle.
  initial begin
    int          gnt_wait;
    int          rv_cnt;
    logic [31:0] rv_addr, prev_addr;
    logic        have_prev;
    gnt_wait = 0; rv_cnt = -1; rv_addr = '0; prev_addr = '0; have_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      a_gnt   = 1'b0;
      a_rv    = 1'b0;
      a_rdata = $urandom;
      if (!mem_auto) begin
        gnt_wait = 0; rv_cnt = -1; have_prev = 1'b0;
      end else begin
        if (rv_cnt == 0) begin
          a_rv    = 1'b1;
          a_rdata = memf(rv_addr);
          rv_cnt  = -1;
        end else if (rv_cnt > 0) begin
          rv_cnt--;
        end else if (!mem_busy && sb.size() == 0 && !bus.imem_req && $urandom_range(0, 7) == 0) begin
          a_rv = 1'b1;
        end
        if (bus.imem_req) begin
          chk("req_expected", {31'b0, req_owed}, 32'h1);
          chk("imem_addr", bus.imem_addr, exp_req_addr);
          if (have_prev) chk("imem_addr_stable", bus.imem_addr, prev_addr);
          if (gnt_wait == 0) begin
            a_gnt     = 1'b1;
            req_owed  = 1'b0;
            rv_cnt    = $urandom_range(0, 2);
            rv_addr   = bus.imem_addr;
            gnt_wait  = $urandom_range(0, 3);
            have_prev = 1'b0;
          end else begin
            gnt_wait--;
            have_prev = 1'b1;
            prev_addr = bus.imem_addr;
          end
        end else if (have_prev) begin
          chk("imem_req_withdrawn", 32'h0, 32'h1);
          have_prev = 1'b0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] tmp;
    int          r;
    bus.pc_in = '0; bus.pc_valid = 1'b0; bus.flush = 1'b0; bus.instr_ready = 1'b0;

    // reset with gnt/rvalid toggling
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      man_gnt = ~man_gnt;
      man_rv  = ~man_rv;
      man_rdata = 32'hDEAD_BEEF;
      tick();
      chk_zero("reset");
    end
    man_gnt = 1'b0; man_rv = 1'b0;
    rst = 1'b1;
    tick();

    // basic fetch, fixed latency
    bus.pc_in = 32'h0040_0000; bus.pc_valid = 1'b1;
    tick();
    bus.pc_valid = 1'b0;
    chk("t2_imem_req", {31'b0, bus.imem_req}, 32'h1);
    chk("t2_imem_addr", bus.imem_addr, 32'h0040_0000);
    man_gnt = 1'b1; req_owed = 1'b0;
    tick();
    man_gnt = 1'b0; man_rv = 1'b1; man_rdata = 32'h2008_0005;
    chk("t2_valid_early", {31'b0, bus.instr_valid}, 32'h0);
    tick();
    man_rv = 1'b0; man_rdata = 32'h0;
    chk("t2_instr_valid", {31'b0, bus.instr_valid}, 32'h1);
    chk("t2_instr", bus.instr, 32'h2008_0005);
    chk("t2_pc4", bus.pc4, 32'h0040_0004);
    repeat (3) tick();
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    chk("t2_consumed", {31'b0, bus.instr_valid}, 32'h0);

    // randomized traffic
    mem_auto = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      tmp = $urandom;
      r   = $urandom_range(0, 9);
      if (r == 0)      bus.pc_in = 32'hFFFF_FFFC;
      else if (r == 1) bus.pc_in = {tmp[31:2], 2'(int'($urandom_range(1, 3)))};
      else             bus.pc_in = {tmp[31:2], 2'b00};
      bus.pc_valid    = ($urandom_range(0, 2) != 0);
      bus.flush       = ($urandom_range(0, 11) == 0);
      bus.instr_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    bus.pc_valid = 1'b0; bus.flush = 1'b0; bus.instr_ready = 1'b1;
    for (int i = 0; i < 40 && (sb.size() != 0 || mem_busy); i++) tick();
    chk("drain_scoreboard", sb.size(), 32'h0);
    chk("drain_mem_busy", {31'b0, mem_busy}, 32'h0);
    tick();
    mem_auto = 1'b0;
    bus.instr_ready = 1'b0;
    tick();

    // reset while waiting for data: the late response must be ignored
    bus.pc_in = 32'h0000_0100; bus.pc_valid = 1'b1;
    tick();
    bus.pc_valid = 1'b0;
    man_gnt = 1'b1; req_owed = 1'b0;
    tick();
    man_gnt = 1'b0; rst = 1'b0;
    tick();
    rst = 1'b1; man_rv = 1'b1; man_rdata = memf(32'h0000_0100);
    tick();
    man_rv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t6_instr_valid", {31'b0, bus.instr_valid}, 32'h0);
      chk("t6_imem_req", {31'b0, bus.imem_req}, 32'h0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
